// File: rtl/pipelined_cla_adder.sv
// ---------------------------------------------------------------------------
// pipelined_cla_adder
//   Pipelined carry-lookahead adder/subtractor. A WIDTH-bit operand pair is
//   split into NSTG = WIDTH/BLOCK lookahead groups; one group is resolved per
//   pipeline stage, giving one result per clock at full rate. Valid/ready
//   streaming on both sides with a single global stall.
//
//   Rank 0 registers the raw beat (B already inverted in sub mode). Rank s
//   (1..NSTG) holds the result of groups 0..s-1, so the final rank is the
//   output register and a beat accepted at edge k is presented at edge k+NSTG.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   block accepts a beat this cycle
//   in_a/in_b  operands (WIDTH bits)
//   in_cin     carry in (sub mode: 1 = no borrow in)
//   in_sub     0: A+B+cin, 1: A+~B+cin
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   out_sum    result (WIDTH bits)
//   out_cout   carry out of MSB (sub mode: 1 = no borrow)
//   out_ovf    signed overflow
//
//   WIDTH must be a multiple of BLOCK.
// ---------------------------------------------------------------------------
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NSTG = WIDTH / BLOCK;

    // Pipeline ranks. Operands are only needed by ranks that still have a
    // group left to resolve, so the final rank carries just the result.
    logic             valid_reg [0:NSTG];
    logic [WIDTH-1:0] a_reg     [0:NSTG-1];
    logic [WIDTH-1:0] b_reg     [0:NSTG-1];
    logic [WIDTH-1:0] sum_reg   [0:NSTG];
    logic             carry_reg [0:NSTG];
    logic             ovf_reg;

    logic [WIDTH-1:0] sum_next   [1:NSTG];
    logic             carry_next [1:NSTG];
    logic             ovf_next;

    logic adv;

    // One stall signal for the whole pipe: it moves only when the output
    // register is empty or being drained.
    assign adv      = !valid_reg[NSTG] || out_ready;
    assign in_ready = adv;

    // -----------------------------------------------------------------------
    // Group logic: stage gi resolves bits [gi*BLOCK +: BLOCK] of rank gi.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NSTG; gi++) begin : g_stage
            logic [BLOCK-1:0] ga;
            logic [BLOCK-1:0] gb;
            logic [BLOCK-1:0] g;
            logic [BLOCK-1:0] p;
            logic [BLOCK:0]   c;
            logic             term;
            logic [WIDTH-1:0] sn;

            assign ga = a_reg[gi][gi*BLOCK +: BLOCK];
            assign gb = b_reg[gi][gi*BLOCK +: BLOCK];
            assign g  = ga & gb;
            assign p  = ga ^ gb;

            // Flat sum-of-products lookahead: c[j] = P[j-1:0]&cin | OR_k
            // (g[k] & P[j-1:k+1]). The loops unroll into two-level logic
            // rather than a ripple chain.
            always_comb begin
                c    = '0;
                term = 1'b0;
                c[0] = carry_reg[gi];
                for (int j = 1; j <= BLOCK; j++) begin
                    c[j] = carry_reg[gi];
                    for (int m = 0; m < j; m++) begin
                        c[j] = c[j] & p[m];
                    end
                    for (int k = 0; k < j; k++) begin
                        term = g[k];
                        for (int m = k + 1; m < j; m++) begin
                            term = term & p[m];
                        end
                        c[j] = c[j] | term;
                    end
                end
            end

            // Lower sum bits come forward from the previous rank; this
            // stage fills in its own group.
            always_comb begin
                sn                       = sum_reg[gi];
                sn[gi*BLOCK +: BLOCK]    = p ^ c[BLOCK-1:0];
            end

            assign sum_next[gi+1]   = sn;
            assign carry_next[gi+1] = c[BLOCK];

            // The MSB lives in the last group at local index BLOCK-1.
            if (gi == NSTG - 1) begin : g_msb
                assign ovf_next = c[BLOCK] ^ c[BLOCK-1];
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Rank registers: everything shifts together on adv, or holds.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s <= NSTG; s++) begin
                valid_reg[s] <= 1'b0;
                sum_reg[s]   <= '0;
                carry_reg[s] <= 1'b0;
            end
            for (int s = 0; s < NSTG; s++) begin
                a_reg[s] <= '0;
                b_reg[s] <= '0;
            end
            ovf_reg <= 1'b0;
        end else if (adv) begin
            // Input rank: subtraction is A + ~B + cin, inverted here once.
            valid_reg[0] <= in_valid;
            a_reg[0]     <= in_a;
            b_reg[0]     <= in_sub ? ~in_b : in_b;
            carry_reg[0] <= in_cin;
            sum_reg[0]   <= '0;
            for (int s = 1; s <= NSTG; s++) begin
                valid_reg[s] <= valid_reg[s-1];
                sum_reg[s]   <= sum_next[s];
                carry_reg[s] <= carry_next[s];
            end
            for (int s = 1; s < NSTG; s++) begin
                a_reg[s] <= a_reg[s-1];
                b_reg[s] <= b_reg[s-1];
            end
            ovf_reg <= ovf_next;
        end
    end

    assign out_valid = valid_reg[NSTG];
    assign out_sum   = sum_reg[NSTG];
    assign out_cout  = carry_reg[NSTG];
    assign out_ovf   = ovf_reg;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_cla_adder
//   Self-checking bench for pipelined_cla_adder (WIDTH=16, BLOCK=4).
//   Expected results come from plain integer arithmetic; in-order delivery is
//   tracked with a queue of expected results.
// ---------------------------------------------------------------------------
module tb_pipelined_cla_adder;

    localparam int WIDTH = 16;
    localparam int LAT   = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    int compared;
    int mismatched;

    pipelined_cla_adder #(.WIDTH(16), .BLOCK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: {ovf, cout, sum} from plain arithmetic.
    function automatic logic [17:0] ref_calc(input logic [15:0] a, input logic [15:0] b,
                                             input logic cin, input logic sub);
        logic [15:0] bb;
        logic [16:0] full;
        logic        ovf;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {16'b0, cin};
        ovf  = (a[15] == bb[15]) && (full[15] != a[15]);
        return {ovf, full[16], full[15:0]};
    endfunction

    // -----------------------------------------------------------------------
    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if (out_valid !== 1'b0 || out_sum !== 16'h0 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b ovf=%b expected 0/0000/0/0",
                     out_valid, out_sum, out_cout, out_ovf);
        end
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        $display("reset: outputs cleared, in_ready=%b", in_ready);
    endtask

    // -----------------------------------------------------------------------
    // Single beats through an empty pipe; checks latency and result.
    task automatic test_directed();
        logic [15:0] va [7];
        logic [15:0] vb [7];
        logic        vc [7];
        logic        vs [7];
        logic [17:0] exp_r;
        int          lat;
        va = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h0003, 16'h8000, 16'hABCD};
        vb = '{16'h0000, 16'h0001, 16'h0001, 16'h0003, 16'h0005, 16'h0001, 16'h1234};
        vc = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b1,     1'b1,     1'b1};
        vs = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b1,     1'b1,     1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_a     = va[i];
            in_b     = vb[i];
            in_cin   = vc[i];
            in_sub   = vs[i];
            exp_r    = ref_calc(va[i], vb[i], vc[i], vs[i]);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat = 0;
            for (int n = 1; n <= 8 && lat == 0; n++) begin
                @(posedge clk);
                #1;
                if (out_valid === 1'b1) lat = n;
            end
            compared++;
            if (lat != LAT) begin
                mismatched++;
                $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, LAT);
            end
            compared++;
            if ({out_ovf, out_cout, out_sum} !== exp_r) begin
                mismatched++;
                $display("FAIL directed_result[%0d]: got ovf=%b cout=%b sum=%h expected ovf=%b cout=%b sum=%h",
                         i, out_ovf, out_cout, out_sum, exp_r[17], exp_r[16], exp_r[15:0]);
            end
            $display("directed %0d: a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b lat=%0d",
                     i, va[i], vb[i], vc[i], vs[i], out_sum, out_cout, out_ovf, lat);
        end
    endtask

    // -----------------------------------------------------------------------
    // 16 back-to-back random beats with out_ready toggling every cycle.
    task automatic test_back_to_back();
        logic [17:0] expq [$];
        logic [17:0] held;
        logic [17:0] exp_r;
        logic        hold_pending;
        logic        acc;
        int          sent;
        int          recv;
        int          extra;
        int          stalls;
        sent         = 0;
        recv         = 0;
        stalls       = 0;
        hold_pending = 1'b0;
        held         = '0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 16'($urandom);
        in_b      = 16'($urandom);
        in_cin    = 1'($urandom);
        in_sub    = 1'($urandom);
        for (int cyc = 0; cyc < 200 && recv < 16; cyc++) begin
            @(negedge clk);
            compared++;
            if (in_ready !== (!out_valid || out_ready)) begin
                mismatched++;
                $display("FAIL b2b_in_ready cycle %0d: got %b expected %b", cyc, in_ready,
                         (!out_valid || out_ready));
            end
            if (in_ready === 1'b0) stalls++;
            if (hold_pending) begin
                compared++;
                if (out_valid !== 1'b1 || {out_ovf, out_cout, out_sum} !== held) begin
                    mismatched++;
                    $display("FAIL b2b_hold cycle %0d: got valid=%b res=%h expected valid=1 res=%h",
                             cyc, out_valid, {out_ovf, out_cout, out_sum}, held);
                end
            end
            hold_pending = (out_valid === 1'b1) && (out_ready === 1'b0);
            held         = {out_ovf, out_cout, out_sum};
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                compared++;
                if (expq.size() == 0) begin
                    mismatched++;
                    $display("FAIL b2b_unexpected_beat: got sum=%h expected no beat", out_sum);
                end else begin
                    exp_r = expq.pop_front();
                    if ({out_ovf, out_cout, out_sum} !== exp_r) begin
                        mismatched++;
                        $display("FAIL b2b_result[%0d]: got ovf=%b cout=%b sum=%h expected ovf=%b cout=%b sum=%h",
                                 recv, out_ovf, out_cout, out_sum, exp_r[17], exp_r[16], exp_r[15:0]);
                    end
                end
                $display("b2b beat %0d: sum=%h cout=%b ovf=%b", recv, out_sum, out_cout, out_ovf);
                recv++;
            end
            acc = (in_valid === 1'b1) && (in_ready === 1'b1);
            if (acc) begin
                expq.push_back(ref_calc(in_a, in_b, in_cin, in_sub));
                sent++;
            end
            @(posedge clk);
            #1;
            out_ready = ~out_ready;
            if (acc) begin
                if (sent < 16) begin
                    in_a   = 16'($urandom);
                    in_b   = 16'($urandom);
                    in_cin = 1'($urandom);
                    in_sub = 1'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        compared++;
        if (recv != 16 || sent != 16) begin
            mismatched++;
            $display("FAIL b2b_count: got sent=%0d recv=%0d expected 16/16", sent, recv);
        end
        compared++;
        if (stalls == 0) begin
            mismatched++;
            $display("FAIL b2b_stalls: got %0d stalled cycles expected at least 1", stalls);
        end
        // Drain: no further beats may appear.
        out_ready = 1'b1;
        in_valid  = 1'b0;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid === 1'b1) extra++;
            @(posedge clk);
        end
        compared++;
        if (extra != 0) begin
            mismatched++;
            $display("FAIL b2b_duplicates: got %0d extra beats expected 0", extra);
        end
    endtask

    // -----------------------------------------------------------------------
    // in_valid 1,0,0,1 -> out_valid 1,0,0,1 four cycles later.
    task automatic test_bubbles();
        logic        pat [4];
        logic        expv [9];
        logic [17:0] expq [$];
        logic [17:0] exp_r;
        logic [15:0] ra;
        logic [15:0] rb;
        pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
        // Observed after each edge starting at the first acceptance edge.
        expv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int e = 0; e < 9; e++) begin
            if (e < 4) begin
                ra       = 16'($urandom);
                rb       = 16'($urandom);
                in_valid = pat[e];
                in_a     = ra;
                in_b     = rb;
                in_cin   = 1'b0;
                in_sub   = 1'b0;
                if (pat[e]) expq.push_back(ref_calc(ra, rb, 1'b0, 1'b0));
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            compared++;
            if (out_valid !== expv[e]) begin
                mismatched++;
                $display("FAIL bubble_valid edge %0d: got %b expected %b", e, out_valid, expv[e]);
            end
            if (out_valid === 1'b1 && expv[e] && expq.size() > 0) begin
                exp_r = expq.pop_front();
                compared++;
                if ({out_ovf, out_cout, out_sum} !== exp_r) begin
                    mismatched++;
                    $display("FAIL bubble_result edge %0d: got %h expected %h", e,
                             {out_ovf, out_cout, out_sum}, exp_r);
                end
                $display("bubble beat at edge %0d: sum=%h cout=%b", e, out_sum, out_cout);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    // Reset while beats are in flight: immediate clear, no leftovers after.
    task automatic test_reset_midstream();
        int          seen;
        int          lat;
        logic [17:0] exp_r;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_cin   = 1'b0;
        in_sub   = 1'b0;
        in_a     = 16'h1111;
        in_b     = 16'h2222;
        repeat (6) begin
            @(posedge clk);
            #1;
            in_a = 16'($urandom) | 16'h0100;
            in_b = 16'($urandom);
        end
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL midreset_prefill: got out_valid=%b expected 1", out_valid);
        end
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        compared++;
        if (out_valid !== 1'b0 || out_sum !== 16'h0 || out_cout !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_clear: got valid=%b sum=%h cout=%b expected 0/0000/0",
                     out_valid, out_sum, out_cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        compared++;
        if (seen != 0) begin
            mismatched++;
            $display("FAIL midreset_leftover: got %0d stale beats expected 0", seen);
        end
        // First beat after release must see an empty pipe.
        in_valid = 1'b1;
        in_a     = 16'h1234;
        in_b     = 16'h4321;
        in_cin   = 1'b1;
        in_sub   = 1'b0;
        exp_r    = ref_calc(16'h1234, 16'h4321, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 8 && lat == 0; n++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) lat = n;
        end
        compared++;
        if (lat != LAT || {out_ovf, out_cout, out_sum} !== exp_r) begin
            mismatched++;
            $display("FAIL midreset_first_beat: got lat=%0d res=%h expected lat=%0d res=%h",
                     lat, {out_ovf, out_cout, out_sum}, LAT, exp_r);
        end
        $display("post-reset beat: sum=%h cout=%b lat=%0d", out_sum, out_cout, lat);
    endtask

    // -----------------------------------------------------------------------
    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_bubbles();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
